// File: rtl/even_parity_pkg.sv
// Shared types and line constants for the even-parity serial receiver.
// Imported by the receiver top and its parity checker.
package even_parity_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/even_parity_checker.sv
// Combinational even-parity check over a data+parity vector.
// err is high when the vector holds an odd number of ones.
module even_parity_checker #(
   parameter int W = 5
) (
   input  logic [W-1:0] bits,
   output logic         err
);

   // Reduction XOR: zero for an even count of ones
   always_comb begin
      err = ^bits;
   end

endmodule

// File: rtl/even_parity_serial_rx.sv
// Even-parity serial receiver: start, DATA_W bits LSB first, parity, stop.
// Advances only on bit_valid strobes; reports each frame with a data_valid pulse.
module even_parity_serial_rx
   import even_parity_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bit_valid,
   input  logic              rx_bit,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   rx_state_t         state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_nxt;
   logic              par;
   logic              perr_c;

   even_parity_checker #(
      .W(DATA_W + 1)
   ) u_chk (
      .bits({shreg, par}),
      .err (perr_c)
   );

   // Place the incoming bit at the position selected by the bit counter
   always_comb begin
      shreg_nxt = shreg;
      for (int i = 0; i < DATA_W; i++) begin
         if (cnt == CNT_W'(i)) begin
            shreg_nxt[i] = rx_bit;
         end
      end
   end

   // Frame FSM, bit counter and shift register; idle strobes hold everything
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
         par   <= 1'b0;
      end else if (bit_valid) begin
         unique case (state)
            IDLE: begin
               if (rx_bit == START_BIT) begin
                  state <= DATA;
                  cnt   <= '0;
               end
            end
            DATA: begin
               shreg <= shreg_nxt;
               if (cnt == LAST) begin
                  state <= PARITY;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PARITY: begin
               par   <= rx_bit;
               state <= STOP;
            end
            STOP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Result registers update only on the stop strobe; data_valid is a 1-cycle pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (bit_valid && state == STOP) begin
            data_out   <= shreg;
            parity_err <= perr_c;
            frame_err  <= (rx_bit != STOP_BIT);
            data_valid <= 1'b1;
         end
      end
   end

   // Busy spans the frame from the accepted start bit to the stop strobe
   always_comb begin
      busy = (state != IDLE);
   end

endmodule

// File: tb/tb_even_parity_serial_rx.sv
// Scoreboard bench for even_parity_serial_rx with DATA_W=4.
// Stimulus pushes expected frames; a monitor pops on every data_valid.
module tb_even_parity_serial_rx;

   typedef struct {
      logic [3:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       bit_valid;
   logic       rx_bit;
   logic [3:0] data_out;
   logic       data_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   int   checks;
   int   failures;
   exp_t exp_q[$];

   even_parity_serial_rx #(
      .DATA_W(4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_valid (bit_valid),
      .rx_bit    (rx_bit),
      .data_out  (data_out),
      .data_valid(data_valid),
      .parity_err(parity_err),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: timeout act=running req=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: act=%0h req=%0h", name, act, req);
      end
   endtask

   // Monitor: every data_valid must match the oldest expected frame
   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_pulse: act=data_valid req=none");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("data_out", {28'd0, data_out}, {28'd0, e.d});
            check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
            check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
         end
      end
   end

   task automatic send_bit(input logic b, input int gap);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      bit_valid = 1'b1;
      rx_bit    = b;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      rx_bit    = 1'b1;
   endtask

   task automatic send_frame(input logic [3:0] d, input logic p,
                             input logic s, input logic pe,
                             input logic fe, input int maxgap);
      exp_t e;
      send_bit(1'b0, $urandom_range(0, maxgap));
      check("busy_start", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         send_bit(d[i], $urandom_range(0, maxgap));
      end
      send_bit(p, $urandom_range(0, maxgap));
      e.d  = d;
      e.pe = pe;
      e.fe = fe;
      exp_q.push_back(e);
      send_bit(s, $urandom_range(0, maxgap));
      check("dv_latency", {31'd0, data_valid}, 32'd1);
      check("busy_end", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      bit_valid = 1'b0;
      rx_bit    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data_out", {28'd0, data_out}, 32'd0);
      check("rst_valid", {31'd0, data_valid}, 32'd0);
      check("rst_perr", {31'd0, parity_err}, 32'd0);
      check("rst_ferr", {31'd0, frame_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 4'hB, good parity and stop
      send_frame(4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      // 4'hB with wrong parity bit
      send_frame(4'hB, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      // 4'h5, parity 0, stop sampled low
      send_frame(4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 0);

      // Idle line for 20 strobes must not start a frame
      for (int i = 0; i < 20; i++) begin
         send_bit(1'b1, 0);
      end
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_hold", {28'd0, data_out}, 32'h5);
      // 4'h3 with strobe gaps of 0..3 cycles
      send_frame(4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 3);

      // Reset while waiting for the parity bit
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      send_bit(1'b1, 0);
      send_bit(1'b0, 0);
      send_bit(1'b0, 0);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("mid_rst_data_out", {28'd0, data_out}, 32'd0);
      check("mid_rst_valid", {31'd0, data_valid}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
      // Remaining bits of the aborted frame on an idle receiver
      send_bit(1'b1, 0);
      send_bit(1'b1, 0);
      // Clean 4'hA afterwards
      send_frame(4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 0);

      // All 16 values back-to-back with correct parity
      for (int v = 0; v < 16; v++) begin
         logic [3:0] d;
         d = 4'(v);
         send_frame(d, ^d, 1'b1, 1'b0, 1'b0, 0);
      end

      repeat (4) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
